// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: pipeline flow control for a 5-stage MIPS-style core.
// It tracks the multiply/divide unit busy window, merges RAW hazard and MDU
// stalls into the F/D enables and the E bubble, prioritises exceptions over
// every stall, selects the next-PC source and counts stalled cycles.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   hz_stall_D  in   RAW hazard stall request from D-stage hazard detector
//   md_start_E  in   mult/multu/div/divu present in E this cycle
//   md_div_E    in   1 = div/divu, 0 = mult/multu (qualifies md_start_E)
//   md_use_D    in   instruction in D uses the MDU or HI/LO
//   exc_req_M   in   exception/interrupt taken at M
//   eret_D      in   eret present in D
//   en_F        out  PC write enable (combinational)
//   en_D        out  REG_D load enable (combinational)
//   clr_E       out  REG_E bubble insert (combinational)
//   exc_int     out  flush of all pipeline registers (combinational)
//   pc_sel      out  next-PC source: 00 seq/branch, 01 handler, 10 EPC
//   md_busy     out  MDU operation in progress (decoded from state)
//   md_cnt      out  remaining MDU busy cycles (registered)
//   stall_cnt   out  saturating count of stalled cycles (registered)
module pipe_flow_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        hz_stall_D,
    input  logic        md_start_E,
    input  logic        md_div_E,
    input  logic        md_use_D,
    input  logic        exc_req_M,
    input  logic        eret_D,
    output logic        en_F,
    output logic        en_D,
    output logic        clr_E,
    output logic        exc_int,
    output logic [1:0]  pc_sel,
    output logic        md_busy,
    output logic [3:0]  md_cnt,
    output logic [15:0] stall_cnt
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SC_W  = 16;
    localparam int unsigned SEL_W = 2;

    localparam logic [CNT_W-1:0] MULT_CYC = CNT_W'(5);
    localparam logic [CNT_W-1:0] DIV_CYC  = CNT_W'(10);

    localparam logic [SEL_W-1:0] PC_SEQ  = SEL_W'(0);
    localparam logic [SEL_W-1:0] PC_EXC  = SEL_W'(1);
    localparam logic [SEL_W-1:0] PC_EPC  = SEL_W'(2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_next;
    logic             md_stall;
    logic             stall;

    // State and MDU countdown register
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= cnt_next;
        end
    end

    // Next state, countdown and pipeline control outputs
    always_comb begin
        state_next = state;
        cnt_next   = md_cnt;
        md_busy    = 1'b0;
        md_stall   = 1'b0;
        stall      = 1'b0;
        en_F       = 1'b1;
        en_D       = 1'b1;
        clr_E      = 1'b0;
        exc_int    = 1'b0;
        pc_sel     = PC_SEQ;

        // A start that coincides with an exception is being flushed, so it
        // must not load; a new start always restarts the countdown.
        if (md_start_E && !exc_req_M) begin
            cnt_next   = md_div_E ? DIV_CYC : MULT_CYC;
            state_next = BUSY;
        end else if (state == BUSY) begin
            cnt_next = md_cnt - CNT_W'(1);
            if (md_cnt == CNT_W'(1)) begin
                state_next = IDLE;
            end
        end

        md_busy  = (state == BUSY);
        md_stall = md_use_D && (md_busy || md_start_E);
        stall    = (hz_stall_D || md_stall) && !exc_req_M;

        en_F    = !stall;
        en_D    = !stall;
        clr_E   = stall;
        exc_int = exc_req_M;

        // EPC is taken only when REG_D actually advances past the eret.
        if (exc_req_M) begin
            pc_sel = PC_EXC;
        end else if (eret_D && !stall) begin
            pc_sel = PC_EPC;
        end
    end

    // Saturating stalled-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {SC_W{1'b1}})) begin
            stall_cnt <= stall_cnt + SC_W'(1);
        end
    end

endmodule
